// File: rtl/bnn_conv_layer_param_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bnn_conv_layer_param_pkg: sizing helpers and stage-1 flag type
// shared by the BNN convolution layer and its window buffer.
// Rev 1.0
// ------------------------------------------------------------------
package bnn_conv_layer_param_pkg;

  localparam int DEF_IMG_W = 13;
  localparam int DEF_IMG_H = 13;
  localparam int DEF_C_IN  = 8;
  localparam int DEF_C_OUT = 16;
  localparam int DEF_K     = 3;

  typedef struct packed {
    logic valid;
    logic last;
  } s1_flags_t;

  // Popcount range is 0..N, thresholds go up to N+1.
  function automatic int bnn_pcw(input int n);
    return $clog2(n + 2);
  endfunction

  function automatic int bnn_out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  function automatic int bnn_maj_th(input int n);
    return n / 2 + 1;
  endfunction

  function automatic int bnn_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_conv_layer_param_window_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// bnn_conv_layer_param_window_buffer: raster counters, K-1 line buffers
// and KxK shift window; flags complete windows one edge after the pixel.
// Rev 1.0
// ------------------------------------------------------------------
module bnn_conv_layer_param_window_buffer
  import bnn_conv_layer_param_pkg::*;
#(
  parameter  int IMG_W = DEF_IMG_W,
  parameter  int IMG_H = DEF_IMG_H,
  parameter  int C_IN  = DEF_C_IN,
  parameter  int K     = DEF_K,
  localparam int N     = K * K * C_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [C_IN-1:0] pixel_in,
  output logic [N-1:0]    win_o,
  output s1_flags_t       s1_o
);

  localparam int CW = bnn_idx_w(IMG_W);
  localparam int RW = bnn_idx_w(IMG_H);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  s1_flags_t       s1_q, s1_d;
  logic            col_end, row_end, complete;

  logic [C_IN-1:0] lb_q   [K-1][IMG_W];
  logic [C_IN-1:0] win_q  [K][K];
  logic [C_IN-1:0] newcol [K];

  assign col_end  = (col_q == CW'(IMG_W - 1));
  assign row_end  = (row_q == RW'(IMG_H - 1));
  assign complete = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    s1_d  = '0;
    if (valid_in) begin
      s1_d.valid = complete;
      s1_d.last  = col_end && row_end;
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Column entering the window: oldest buffered row first, live pixel last.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      newcol[r] = lb_q[K-2-r][col_q];
    end
    newcol[K-1] = pixel_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      s1_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      s1_q  <= s1_d;
    end
  end

  // Storage is never reset; row/col gating keeps stale contents out of results.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb_q[0][col_q] <= pixel_in;
      for (int j = 1; j < K - 1; j++) begin
        lb_q[j][col_q] <= lb_q[j-1][col_q];
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][K-1] <= newcol[r];
      end
    end
  end

  always_comb begin
    win_o = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_o[(r*K + c)*C_IN +: C_IN] = win_q[r][c];
      end
    end
  end

  assign s1_o = s1_q;

endmodule
`default_nettype wire

// File: rtl/bnn_conv_layer_param.sv
`default_nettype none
// ------------------------------------------------------------------
// bnn_conv_layer_param: streaming KxK binary convolution, C_OUT
// XNOR-popcount-threshold lanes with run-time loadable weights.
// Rev 1.0
// ------------------------------------------------------------------
module bnn_conv_layer_param
  import bnn_conv_layer_param_pkg::*;
#(
  parameter  int IMG_W = DEF_IMG_W,
  parameter  int IMG_H = DEF_IMG_H,
  parameter  int C_IN  = DEF_C_IN,
  parameter  int C_OUT = DEF_C_OUT,
  parameter  int K     = DEF_K,
  localparam int N     = K * K * C_IN,
  localparam int PCW   = bnn_pcw(N),
  localparam int CHW   = bnn_idx_w(C_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [C_IN-1:0]  pixel_in,
  input  logic             wt_we,
  input  logic [CHW-1:0]   wt_ch,
  input  logic [N-1:0]     wt_data,
  input  logic [PCW-1:0]   th_data,
  output logic [C_OUT-1:0] pixel_out,
  output logic             valid_out,
  output logic             last_out
);

  logic [N-1:0]     win;
  s1_flags_t        s1;
  logic             wr_en;
  logic [C_OUT-1:0] hit_d;
  logic [C_OUT-1:0] pixel_out_q;
  logic             valid_out_q, last_out_q;

  logic [N-1:0]     wt_q [C_OUT];
  logic [PCW-1:0]   th_q [C_OUT];

  bnn_conv_layer_param_window_buffer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .C_IN  (C_IN),
    .K     (K)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .pixel_in (pixel_in),
    .win_o    (win),
    .s1_o     (s1)
  );

  assign wr_en = wt_we && (32'(wt_ch) < 32'(C_OUT));

  // Lanes read wt_q/th_q before this edge's write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < C_OUT; c++) begin
        wt_q[c] <= '1;
        th_q[c] <= PCW'(bnn_maj_th(N));
      end
    end else if (wr_en) begin
      wt_q[wt_ch] <= wt_data;
      th_q[wt_ch] <= th_data;
    end
  end

  for (genvar c = 0; c < C_OUT; c++) begin : g_lane
    logic [N-1:0]   match;
    logic [PCW-1:0] pc;

    assign match = ~(win ^ wt_q[c]);

    always_comb begin
      pc = '0;
      for (int i = 0; i < N; i++) begin
        pc = pc + PCW'(match[i]);
      end
    end

    assign hit_d[c] = (pc >= th_q[c]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_out_q <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      valid_out_q <= s1.valid;
      last_out_q  <= s1.last;
      if (s1.valid) begin
        pixel_out_q <= hit_d;
      end
    end
  end

  assign pixel_out = pixel_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bnn_conv_layer_param.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_bnn_conv_layer_param: scoreboard bench for the streaming BNN conv layer.
// Rev 1.0
// ------------------------------------------------------------------
module tb_bnn_conv_layer_param;

  localparam int IMG_W = 13;
  localparam int IMG_H = 13;
  localparam int C_IN  = 8;
  localparam int C_OUT = 16;
  localparam int K     = 3;
  localparam int N     = K * K * C_IN;
  localparam int PCW   = 7;
  localparam int NPIX  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [C_IN-1:0]  pixel_in = '0;
  logic             wt_we = 1'b0;
  logic [3:0]       wt_ch = '0;
  logic [N-1:0]     wt_data = '0;
  logic [PCW-1:0]   th_data = '0;
  logic [C_OUT-1:0] pixel_out;
  logic             valid_out;
  logic             last_out;

  bnn_conv_layer_param dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .pixel_in  (pixel_in),
    .wt_we     (wt_we),
    .wt_ch     (wt_ch),
    .wt_data   (wt_data),
    .th_data   (th_data),
    .pixel_out (pixel_out),
    .valid_out (valid_out),
    .last_out  (last_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C_OUT-1:0] pix;
    logic             last;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_errors = 0;

  logic [C_IN-1:0]  img [IMG_H][IMG_W];
  logic [N-1:0]     mw  [C_OUT];
  logic [PCW-1:0]   mth [C_OUT];
  int               row = 0, col = 0;
  logic             pend_v = 1'b0, pend_last = 1'b0;
  logic [N-1:0]     pend_win = '0;
  logic [C_OUT-1:0] held = '0;
  logic             prev_v = 1'b0;
  int               n_pulse = 0, n_last = 0, n_adj = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] build_win(input int r, input int c);
    logic [N-1:0] w = '0;
    for (int wr = 0; wr < K; wr++)
      for (int wc = 0; wc < K; wc++)
        w[(wr*K + wc)*C_IN +: C_IN] = img[r-K+1+wr][c-K+1+wc];
    return w;
  endfunction

  function automatic logic [C_OUT-1:0] eval_win(input logic [N-1:0] w);
    logic [C_OUT-1:0] e = '0;
    for (int co = 0; co < C_OUT; co++)
      e[co] = ($countones(~(w ^ mw[co])) >= int'(mth[co]));
    return e;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    pend_v = 1'b0;
    row = 0;
    col = 0;
    held = '0;
    for (int co = 0; co < C_OUT; co++) begin
      mw[co]  = '1;
      mth[co] = PCW'(N / 2 + 1);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (valid_out) begin
      n_pulse++;
      if (last_out) n_last++;
      if (prev_v) n_adj++;
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 64'(valid_out), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("pixel_out", 64'(pixel_out), 64'(e.pix));
        chk("last_out", 64'(last_out), 64'(e.last));
        held = e.pix;
      end
    end else begin
      chk("valid_missing", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
      chk("stray_last", 64'(last_out), 64'(0));
      chk("pixel_hold", 64'(pixel_out), 64'(held));
    end
    prev_v = valid_out;
  endtask

  // One clock: drive, let the edge happen, advance the model, check at negedge.
  task automatic step(input logic v, input logic [C_IN-1:0] p, input logic we,
                      input logic [3:0] ch, input logic [N-1:0] wd, input logic [PCW-1:0] th);
    exp_t e;
    valid_in = v;
    pixel_in = p;
    wt_we    = we;
    wt_ch    = ch;
    wt_data  = wd;
    th_data  = th;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pend_v) begin
        e.pix  = eval_win(pend_win);
        e.last = pend_last;
        sb_q.push_back(e);
      end
      if (we) begin
        mw[ch]  = wd;
        mth[ch] = th;
      end
      pend_v = 1'b0;
      if (v) begin
        img[row][col] = p;
        if (row >= K - 1 && col >= K - 1) begin
          pend_v    = 1'b1;
          pend_last = (row == IMG_H - 1) && (col == IMG_W - 1);
          pend_win  = build_win(row, col);
        end
        if (col == IMG_W - 1) begin
          col = 0;
          row = (row == IMG_H - 1) ? 0 : row + 1;
        end else begin
          col = col + 1;
        end
      end
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic px(input logic [C_IN-1:0] p);
    step(1'b1, p, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [3:0] ch, input logic [N-1:0] wd, input logic [PCW-1:0] th);
    step(1'b0, '0, 1'b1, ch, wd, th);
  endtask

  initial begin
    int p0, l0, a0;

    // Reset held with valid_in high.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b1, C_IN'($urandom), 1'b0, '0, '0, '0);
    rst_n = 1'b1;

    // All-ones frame with default weights.
    p0 = n_pulse; l0 = n_last;
    for (int i = 0; i < NPIX; i++) px('1);
    idle(3);
    chk("c2_pulses", 64'(n_pulse - p0), 64'(121));
    chk("c2_last", 64'(n_last - l0), 64'(1));

    // Ramp with forced-1, forced-0 and all-match channels.
    wr(4'd0, '0, PCW'(0));
    wr(4'd1, '1, PCW'(73));
    wr(4'd2, '1, PCW'(72));
    p0 = n_pulse;
    for (int i = 0; i < NPIX; i++) px(C_IN'(i));
    idle(3);
    chk("c3_pulses", 64'(n_pulse - p0), 64'(121));

    // Same ramp with valid_in toggling.
    p0 = n_pulse; a0 = n_adj;
    for (int i = 0; i < NPIX; i++) begin
      px(C_IN'(i));
      step(1'b0, C_IN'($urandom), 1'b0, '0, '0, '0);
    end
    idle(3);
    chk("c4_pulses", 64'(n_pulse - p0), 64'(121));
    chk("c4_adjacent", 64'(n_adj - a0), 64'(0));

    // Random weights, then a ch3 write on the stage-2 edge of pixel (5,5).
    for (int co = 4; co < C_OUT; co++)
      wr(4'(co), N'({$urandom, $urandom, $urandom}), PCW'($urandom_range(30, 42)));
    p0 = n_pulse;
    for (int i = 0; i < NPIX; i++) begin
      if (i == 5 * IMG_W + 6) step(1'b1, C_IN'(i), 1'b1, 4'd3, '0, PCW'(0));
      else px(C_IN'(i));
    end
    idle(3);
    chk("c6_pulses", 64'(n_pulse - p0), 64'(121));
    chk("c6_bit3_new", 64'(held[3]), 64'(1));

    // Two back-to-back frames, reset at pixel 50 of a third, then a full frame.
    p0 = n_pulse; l0 = n_last;
    for (int i = 0; i < 2 * NPIX + 50; i++) px(C_IN'($urandom));
    rst_n = 1'b0;
    step(1'b1, C_IN'($urandom), 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < NPIX; i++) px(C_IN'($urandom));
    idle(3);
    chk("c5_pulses", 64'(n_pulse - p0), 64'(242 + 19 + 121));
    chk("c5_last", 64'(n_last - l0), 64'(3));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
